// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the mem_arb RAM arbiter and the address decode around it.
// The MEM_ARB_PRIO0_EN build option itself lives in mem_arb.sv.
package mem_arb_pkg;

    // Ceiling log2, never less than 1, so a 2-port arbiter still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam int          NPORTS_DEFAULT = 3;
    localparam logic [3:0]  BASE_DEFAULT   = 4'h0;
    localparam logic [15:0] RD_DEFAULT_VAL = 16'hEEEE;

    typedef logic [clog2(NPORTS_DEFAULT)-1:0] port_idx_t;

    // Which source drives rdata after the most recent read completion.
    typedef enum logic [1:0] {
        RD_SRC_ZERO = 2'd0,
        RD_SRC_RAM  = 2'd1,
        RD_SRC_DEF  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/mem_arb_ram.sv
// Single-port synchronous RAM with a registered read port.
// The body matches the inference template for iCE40 SB_RAM40_4K blocks.
module mem_arb_ram #(
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  we,
    input  logic [DW-1:0]         wdata,
    input  logic                  re,
    output logic [DW-1:0]         rdata
);

    logic [DW-1:0] mem [2**DEPTH_LOG2];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_arb.sv
// N-port round-robin arbiter in front of one synchronous RAM, one access per clock.
// Build option MEM_ARB_PRIO0_EN gives port 0 (debug) absolute priority over the round-robin ports.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int              NPORTS     = NPORTS_DEFAULT,
    parameter int              AW         = 16,
    parameter int              DW         = 16,
    parameter int              DEPTH_LOG2 = 8,
    parameter logic [3:0]      BASE       = BASE_DEFAULT,
    parameter logic [DW-1:0]   RD_DEFAULT = DW'(RD_DEFAULT_VAL)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      req,
    input  logic [NPORTS-1:0]      we,
    input  logic [NPORTS*AW-1:0]   addr,
    input  logic [NPORTS*DW-1:0]   wdata,
    output logic [NPORTS-1:0]      rdy,
    output logic [DW-1:0]          rdata,
    output logic                   busy
);

    localparam int PW = clog2(NPORTS);

`ifdef MEM_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NPORTS-1:0] rdy_q, rdy_d;
    rd_src_e           rd_src_q, rd_src_d;

    logic [NPORTS-1:0] elig;
    logic              gnt_valid;
    int                gnt_idx;
    int                idx;
    logic [AW-1:0]     gnt_addr;
    logic [DW-1:0]     gnt_wdata;
    logic              gnt_we;
    logic              in_range;
    logic              ram_we, ram_re;
    logic [DW-1:0]     ram_rdata;

    // A port in its rdy cycle is not eligible, so a lone requester gets every other cycle.
    always_comb begin
        elig      = req & ~rdy_q;
        gnt_valid = 1'b0;
        gnt_idx   = 0;
        idx       = 0;
        if (PRIO0 && elig[0]) begin
            gnt_valid = 1'b1;
            gnt_idx   = 0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                idx = (int'(ptr_q) + k) % NPORTS;
                if (!gnt_valid && elig[idx] && !(PRIO0 && idx == 0)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        gnt_addr  = addr[gnt_idx*AW +: AW];
        gnt_wdata = wdata[gnt_idx*DW +: DW];
        gnt_we    = we[gnt_idx];
        in_range  = (gnt_addr[AW-1:AW-4] == BASE);
        ram_we    = gnt_valid && gnt_we && in_range;
        ram_re    = gnt_valid && !gnt_we && in_range;
    end

    // Priority grants to port 0 leave the round-robin pointer where it was.
    always_comb begin
        ptr_d    = ptr_q;
        rdy_d    = '0;
        rd_src_d = rd_src_q;
        if (gnt_valid) begin
            rdy_d[gnt_idx] = 1'b1;
            if (!(PRIO0 && gnt_idx == 0)) ptr_d = PW'((gnt_idx + 1) % NPORTS);
            if (!gnt_we) rd_src_d = in_range ? RD_SRC_RAM : RD_SRC_DEF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            rdy_q    <= '0;
            rd_src_q <= RD_SRC_ZERO;
        end else begin
            ptr_q    <= ptr_d;
            rdy_q    <= rdy_d;
            rd_src_q <= rd_src_d;
        end
    end

    mem_arb_ram #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .addr  (gnt_addr[DEPTH_LOG2-1:0]),
        .we    (ram_we),
        .wdata (gnt_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // The RAM output register only moves on in-range reads, so it holds the last value by itself.
    always_comb begin
        case (rd_src_q)
            RD_SRC_RAM: rdata = ram_rdata;
            RD_SRC_DEF: rdata = RD_DEFAULT;
            default:    rdata = '0;
        endcase
    end

    assign rdy  = rdy_q;
    assign busy = gnt_valid;

endmodule
